// File: rtl/game_pkg.sv
// Shared constants for the shot controller: FSM state encoding, screen
// geometry, target rectangle, projectile box size and the velocity helper.
package game_pkg;

  // One-hot flags are decoded from this compact binary state encoding.
  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_AIM     = 3'd1;
  localparam logic [2:0] ST_SHOOT   = 3'd2;
  localparam logic [2:0] ST_ANIMATE = 3'd3;
  localparam logic [2:0] ST_HIT     = 3'd4;
  localparam logic [2:0] ST_MISS    = 3'd5;

  // Launch velocity limits.
  localparam logic [3:0] V_INIT = 4'd5;
  localparam logic [3:0] V_MAX  = 4'd15;

  // Screen geometry, all in 11-bit so position sums never wrap.
  localparam logic [10:0] TGT_X_MIN   = 11'd650;
  localparam logic [10:0] TGT_X_MAX   = 11'd675;
  localparam logic [10:0] TGT_Y_MIN   = 11'd470;
  localparam logic [10:0] TGT_Y_MAX   = 11'd475;
  localparam logic [10:0] GROUND_Y    = 11'd475;
  localparam logic [10:0] RIGHT_EDGE  = 11'd775;
  localparam logic [10:0] TOP_EDGE    = 11'd50;
  localparam logic [10:0] Y_UNDERFLOW = 11'd1000;

  // Projectile box extends this far right/down from its reported corner.
  localparam logic [10:0] BOX_W = 11'd5;
  localparam logic [10:0] BOX_H = 11'd2;

  // Flight-step timeout.
  localparam logic [49:0] T_AIR_MAX = 50'd40;

  // Score ceiling.
  localparam logic [7:0] SCORE_MAX = 8'd255;

  // Saturating +/-1 step; simultaneous inc and dec cancel out.
  function automatic logic [3:0] step_vel(input logic [3:0] v,
                                          input logic inc,
                                          input logic dec);
    logic [3:0] r;
    r = v;
    if (inc && !dec) begin
      if (v != V_MAX) r = v + 4'd1;
    end else if (dec && !inc) begin
      if (v != 4'd0) r = v - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shot_collision.sv
// Registered hit/miss detection for the projectile box against the target
// rectangle and the screen borders. Flags lag the position by one cycle and
// are forced low while 'clear' is asserted so a stale position is never used.
module shot_collision
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [49:0] t_air,
  output logic        hit_f,
  output logic        miss_f
);

  logic hit_q, hit_d;
  logic miss_q, miss_d;
  logic [10:0] x_left, x_right, y_top, y_bot;

  // Box extents and raw overlap/out-of-bounds tests for the current sample.
  always_comb begin
    x_left  = {1'b0, pos_x};
    y_top   = {1'b0, pos_y};
    x_right = x_left + BOX_W;
    y_bot   = y_top + BOX_H;

    hit_d  = (x_right >= TGT_X_MIN) && (x_left <= TGT_X_MAX) &&
             (y_bot >= TGT_Y_MIN) && (y_top <= TGT_Y_MAX);
    miss_d = (y_bot >= GROUND_Y) || (x_right >= RIGHT_EDGE) ||
             (y_top <= TOP_EDGE) || (y_top >= Y_UNDERFLOW) ||
             (t_air >= T_AIR_MAX);

    if (clear) begin
      hit_d  = 1'b0;
      miss_d = 1'b0;
    end
  end

  // Register the flags so the FSM acts on a stable, one-cycle-old result.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_f  = hit_q;
  assign miss_f = miss_q;

endmodule

// File: rtl/shot_controller.sv
// Game-control FSM feeding the projectile animation stage: aim, shoot,
// animate, then show hit/miss for a hold period before aiming again.
// Owns launch velocities vX/vY and the score.
// Build option MISS_PENALTY_EN: when defined, a miss decrements the score
// (saturating at 0); otherwise a miss leaves the score untouched.
module shot_controller
  import game_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnC,
  input  logic [9:0]  projectileCenterX,
  input  logic [9:0]  projectileCenterY,
  input  logic [49:0] t_air,
  output logic [3:0]  vX,
  output logic [3:0]  vY,
  output logic        q_Init,
  output logic        q_Aim,
  output logic        q_P1Shoot,
  output logic        q_Animate,
  output logic        q_Hit,
  output logic        q_Miss,
  output logic [7:0]  score
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [3:0]        vx_q, vx_d;
  logic [3:0]        vy_q, vy_d;
  logic [7:0]        score_q, score_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              clear_flags;
  logic              hit_f, miss_f;

  shot_collision u_collision (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_flags),
    .pos_x  (projectileCenterX),
    .pos_y  (projectileCenterY),
    .t_air  (t_air),
    .hit_f  (hit_f),
    .miss_f (miss_f)
  );

  // Next-state, velocity, score and hold-counter logic.
  always_comb begin
    state_d     = state_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    score_d     = score_q;
    hold_d      = hold_q;
    clear_flags = 1'b0;

    case (state_q)
      ST_INIT: state_d = ST_AIM;

      ST_AIM: begin
        vy_d = step_vel(vy_q, btnU, btnD);
        vx_d = step_vel(vx_q, btnR, btnL);
        if (btnC) state_d = ST_SHOOT;
      end

      ST_SHOOT: begin
        clear_flags = 1'b1;
        state_d     = ST_ANIMATE;
      end

      ST_ANIMATE: begin
        if (hit_f) begin
          state_d = ST_HIT;
          hold_d  = '0;
          if (score_q != SCORE_MAX) score_d = score_q + 8'd1;
        end else if (miss_f) begin
          state_d = ST_MISS;
          hold_d  = '0;
`ifdef MISS_PENALTY_EN
          if (score_q != 8'd0) score_d = score_q - 8'd1;
`else
          score_d = score_q;
`endif
        end
      end

      ST_HIT, ST_MISS: begin
        if (btnC || (hold_q == HOLD_LAST)) begin
          state_d = ST_AIM;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      vx_q    <= V_INIT;
      vy_q    <= V_INIT;
      score_q <= 8'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      score_q <= score_d;
      hold_q  <= hold_d;
    end
  end

  assign vX        = vx_q;
  assign vY        = vy_q;
  assign score     = score_q;
  assign q_Init    = (state_q == ST_INIT);
  assign q_Aim     = (state_q == ST_AIM);
  assign q_P1Shoot = (state_q == ST_SHOOT);
  assign q_Animate = (state_q == ST_ANIMATE);
  assign q_Hit     = (state_q == ST_HIT);
  assign q_Miss    = (state_q == ST_MISS);

endmodule

// File: tb/tb_shot_controller.sv
// Bench for shot_controller with a shortened hold time. Shot results are
// checked through a scoreboard queue drained by a monitor on result entry.
module tb_shot_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnC = 1'b0;
  logic [9:0]  projectileCenterX = 10'd300;
  logic [9:0]  projectileCenterY = 10'd200;
  logic [49:0] t_air = 50'd0;
  logic [3:0]  vX, vY;
  logic        q_Init, q_Aim, q_P1Shoot, q_Animate, q_Hit, q_Miss;
  logic [7:0]  score;

  shot_controller #(.HOLD_CYCLES(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .btnU              (btnU),
    .btnD              (btnD),
    .btnL              (btnL),
    .btnR              (btnR),
    .btnC              (btnC),
    .projectileCenterX (projectileCenterX),
    .projectileCenterY (projectileCenterY),
    .t_air             (t_air),
    .vX                (vX),
    .vY                (vY),
    .q_Init            (q_Init),
    .q_Aim             (q_Aim),
    .q_P1Shoot         (q_P1Shoot),
    .q_Animate         (q_Animate),
    .q_Hit             (q_Hit),
    .q_Miss            (q_Miss),
    .score             (score)
  );

  typedef struct {
    logic       is_hit;
    logic [7:0] score;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   model_score = 0;
  logic prev_hit = 1'b0, prev_miss = 1'b0;

  // 10 ns clock.
  always #5 clk = ~clk;

  // Cycle counter used for result-latency expectations.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on entry to HIT or MISS pop the expected result and compare.
  always @(negedge clk) begin
    if ((q_Hit && !prev_hit) || (q_Miss && !prev_miss)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got hit=%0d miss=%0d expected none", q_Hit, q_Miss);
      end else begin
        mon_e = sb_q.pop_front();
        check_output("result_is_hit", int'(q_Hit), int'(mon_e.is_hit));
        check_output("result_is_miss", int'(q_Miss), int'(!mon_e.is_hit));
        check_output("result_score", int'(score), int'(mon_e.score));
        check_output("result_latency", cyc, mon_e.cyc);
      end
    end
    prev_hit  = q_Hit;
    prev_miss = q_Miss;
  end

  // Fire one shot from AIM and present the given position in the first
  // ANIMATE cycle; returns in the first HIT/MISS cycle unless skip is set.
  task automatic run_shot(input int x, input int y, input int ta,
                          input bit exp_hit, input bit skip);
    exp_t e;
    int   n;
    check_output("pre_shot_aim", int'(q_Aim), 1);
    btnC = 1'b1;
    tick();
    btnC = 1'b0;
    check_output("shoot_pulse", int'(q_P1Shoot), 1);
    tick();
    check_output("shoot_one_cycle", int'(q_P1Shoot), 0);
    check_output("animate_entry", int'(q_Animate), 1);
    projectileCenterX = 10'(x);
    projectileCenterY = 10'(y);
    t_air = 50'(ta);
    if (exp_hit) model_score = (model_score == 255) ? 255 : model_score + 1;
`ifdef MISS_PENALTY_EN
    else model_score = (model_score == 0) ? 0 : model_score - 1;
`endif
    e.is_hit = exp_hit;
    e.score  = 8'(model_score);
    e.cyc    = cyc + 2;
    sb_q.push_back(e);
    n = 0;
    while (!(q_Hit || q_Miss) && n < 8) begin
      tick();
      n++;
    end
    projectileCenterX = 10'd300;
    projectileCenterY = 10'd200;
    t_air = 50'd0;
    if (!(q_Hit || q_Miss)) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout: got no result expected hit=%0d", exp_hit);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
    if (skip) begin
      @(negedge clk);
      #1;
      btnC = 1'b1;
      tick();
      btnC = 1'b0;
      check_output("skip_to_aim", int'(q_Aim), 1);
    end
  endtask

  task automatic pulse_btns(input bit u, input bit d, input bit l, input bit r);
    btnU = u; btnD = d; btnL = l; btnR = r;
    tick();
    btnU = 1'b0; btnD = 1'b0; btnL = 1'b0; btnR = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int n;
    reset = 1'b1;
    tick();
    tick();
    check_output("reset_init", int'(q_Init), 1);
    check_output("reset_aim", int'(q_Aim), 0);
    check_output("reset_vx", int'(vX), 5);
    check_output("reset_vy", int'(vY), 5);
    check_output("reset_score", int'(score), 0);
    reset = 1'b0;
    tick();
    check_output("init_to_aim", int'(q_Aim), 1);

    // Velocity saturation and cancellation.
    repeat (10) pulse_btns(1, 0, 0, 0);
    check_output("vy_sat_high", int'(vY), 15);
    repeat (20) pulse_btns(0, 0, 1, 0);
    check_output("vx_sat_low", int'(vX), 0);
    pulse_btns(1, 1, 0, 0);
    check_output("vy_ud_cancel", int'(vY), 15);
    pulse_btns(0, 0, 1, 1);
    check_output("vx_lr_cancel", int'(vX), 0);
    repeat (3) pulse_btns(0, 0, 0, 1);
    check_output("vx_inc", int'(vX), 3);
    pulse_btns(0, 1, 0, 0);
    check_output("vy_dec", int'(vY), 14);

    // Ground miss at score 0.
    run_shot(300, 473, 0, 1'b0, 1'b1);

    // Hit, then let the hold counter run out.
    run_shot(655, 471, 0, 1'b1, 1'b0);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (q_Hit) n++;
      else break;
    end
    check_output("hold_length", n, 16);
    check_output("hold_to_aim", int'(q_Aim), 1);

    // Hit and ground together: hit wins; skip the hold in its third cycle.
    run_shot(660, 473, 0, 1'b1, 1'b0);
    tick();
    tick();
    btnC = 1'b1;
    tick();
    btnC = 1'b0;
    check_output("skip_cycle3_aim", int'(q_Aim), 1);
    check_output("skip_keep_vx", int'(vX), 3);
    check_output("skip_keep_vy", int'(vY), 14);

    run_shot(655, 471, 0, 1'b1, 1'b1);
    run_shot(300, 473, 0, 1'b0, 1'b1);
    run_shot(300, 1010, 0, 1'b0, 1'b1);
    run_shot(300, 200, 40, 1'b0, 1'b1);
    run_shot(770, 200, 0, 1'b0, 1'b1);
    run_shot(300, 50, 0, 1'b0, 1'b1);
    run_shot(645, 468, 0, 1'b1, 1'b1);

    // Reset in the middle of ANIMATE.
    btnC = 1'b1;
    tick();
    btnC = 1'b0;
    tick();
    check_output("pre_reset_animate", int'(q_Animate), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_score = 0;
    check_output("midreset_init", int'(q_Init), 1);
    check_output("midreset_score", int'(score), 0);
    check_output("midreset_vx", int'(vX), 5);
    check_output("midreset_vy", int'(vY), 5);
    tick();
    check_output("midreset_aim", int'(q_Aim), 1);

    // Drive the score to its ceiling and one past it.
    for (int i = 0; i < 256; i++) run_shot(655, 471, 0, 1'b1, 1'b1);
    check_output("score_saturated", int'(score), 255);

    repeat (3) tick();
    check_output("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
